regtrace_streamer: RTL and testbench
====================================

# regtrace_streamer

Synthesizable successor to the per-clock register dump used in CPU simulation. On every retired instruction it latches PC, instruction word and a flattened architectural register-file snapshot, then serializes them as a tagged word stream over a valid/ready interface. It is parametrised in data width and register count, and adds a delta mode (only changed registers) and halt-on-zero-instruction. It sits between the pipeline's write-back stage and a trace sink: a UART/FIFO on the board, or a bench file writer in simulation.

## Interface
- XLEN, 32, data width of PC, instruction and each register
- NREG, 32, number of architectural registers in the snapshot (≥2)
- HALT_ON_ZERO, 1, when 1 a commit with inst==0 halts the block
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- delta_mode  in  1  0 = emit all registers; 1 = emit only registers changed since the last emitted frame; sampled at commit acceptance
- commit_valid  in  1  retired-instruction strobe
- commit_ready  out  1  block can accept a commit
- commit_pc  in  XLEN  PC of retired instruction
- commit_inst  in  XLEN  instruction word
- commit_regs  in  NREG*XLEN  register snapshot; reg i at [i*XLEN +: XLEN]
- out_valid  out  1  stream word valid
- out_ready  in  1  sink accepts word
- out_kind  out  2  0 = PC, 1 = INST, 2 = REG
- out_idx  out  $clog2(NREG)  register index, 0 for PC/INST
- out_data  out  XLEN  payload
- out_last  out  1  final word of frame
- halted  out  1  zero instruction seen (sticky)
- frame_cnt  out  32  completed frames

## Operation
- States: IDLE, PC, INST, SCAN, HALT.
- IDLE: commit_ready=1. A commit is accepted when commit_valid&&commit_ready.
  - If HALT_ON_ZERO and commit_inst==0: go to HALT, set halted, emit nothing.
  - Otherwise: latch pc, inst, regs and delta_mode, then go to PC.
- PC: out_valid=1, kind 0. Advance to INST on handshake.
- INST: kind 1, idx 0. Advance to SCAN with idx=0 on handshake.
- SCAN: one index examined per cycle.
  - Register i is emitted when the latched mode is full, OR shadow_valid==0, OR regs[i]!=shadow[i].
  - Emitted index: out_valid=1, kind 2, data regs[i]. Wait for handshake, then copy regs[i] into shadow[i].
  - Skipped index: out_valid=0 for one cycle.
  - After index NREG-1 is handshaken or skipped: go to IDLE, set shadow_valid, increment frame_cnt (wraps at 2^32).
- out_last: asserted on the last word of the frame. That is the word for the highest index still to be emitted, or INST if SCAN would emit nothing. The block precomputes the remaining-change mask at INST entry.
- A delta frame with no changed registers is PC, INST(last). The block returns to IDLE without entering SCAN.
- HALT: commit_ready=0 and out_valid=0 until rst.
- commit_ready=1 only in IDLE. Commits arriving while busy are stalled upstream, never dropped.
- Reset values: state IDLE, commit_ready=1, out_valid=0, out_kind=0, out_idx=0, out_data=0, out_last=0, halted=0, frame_cnt=0, shadow_valid=0. Shadow contents are don't-care.

## Timing
- Commit accepted at edge T: PC word valid from T+1. Minimum full-mode frame is NREG+2 cycles under out_ready=1.
- out_* are registered and stay stable while out_valid&&!out_ready (AXI-stream rules).
- Next commit is accepted at the earliest on the cycle after the last-word handshake. There is no overlap between frames.
- rst mid-frame: the stream is aborted with no out_last, out_valid=0 on the next cycle, and the partial frame is not counted.
- Reset has priority over a simultaneous commit.

## Structure
- Package regtrace_pkg holds the kind encoding (KIND_PC=0, KIND_INST=1, KIND_REG=2) and the state enum.
- Optional sub-module regtrace_change_mask: combinational NREG-bit compare against the shadow, plus a highest-set-bit finder for out_last.
- The snapshot and shadow are flat registers inside the top module.

## Test plan
- Full mode, NREG=32, out_ready=1, commit pc=0x00400000, inst=0x20080005, regs[i]=i → 34 words: PC, INST, REG 0..31 with data=i, out_last on REG 31, frame_cnt=1.
- Backpressure: toggle out_ready randomly during the same frame → identical word sequence, data held stable while stalled, commit_ready=0 throughout.
- Delta mode: first frame emits all 32 registers. Second commit changes only reg 8 to 0x5 → PC, INST, REG 8 (last). Third commit with no changes → PC, INST (last).
- HALT_ON_ZERO: commit with inst=0 → no output, halted=1, commit_ready=0. Further commit_valid is ignored. After rst, halted=0.
- Reset mid-SCAN at idx 10 → out_valid=0 next cycle, frame_cnt unchanged, and the next frame in delta mode emits all registers.
- Commit held during a busy frame → it is accepted the cycle after out_last's handshake and its PC word follows one cycle later.

Source files
------------

// File: rtl/regtrace_pkg.sv
// Shared encodings for the register-trace streamer: stream word kinds and
// the frame sequencer states.
package regtrace_pkg;

   localparam logic [1:0] KIND_PC   = 2'd0;
   localparam logic [1:0] KIND_INST = 2'd1;
   localparam logic [1:0] KIND_REG  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PC,
      ST_INST,
      ST_SCAN,
      ST_HALT
   } state_t;

endpackage

// File: rtl/regtrace_change_mask.sv
// Per-register change detection against the shadow copy, plus the index of
// the highest register that will be emitted (drives out_last).
module regtrace_change_mask #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input  logic [NREG*XLEN-1:0]      regs,
   input  logic [NREG*XLEN-1:0]      shadow,
   input  logic                      force_all,
   output logic [NREG-1:0]           mask,
   output logic                      any,
   output logic [$clog2(NREG)-1:0]   last_idx
);

   localparam int unsigned IW = $clog2(NREG);

   always_comb begin
      logic hit;
      mask     = '0;
      any      = 1'b0;
      last_idx = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         hit = force_all || (regs[i*XLEN +: XLEN] != shadow[i*XLEN +: XLEN]);
         mask[i] = hit;
         // Ascending scan: the final hit wins, giving the highest set bit.
         if (hit) begin
            any      = 1'b1;
            last_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/regtrace_streamer.sv
// Latches a retired-instruction snapshot and streams it as PC, INST and REG
// words over valid/ready, optionally only the registers changed since the last frame.
module regtrace_streamer
   import regtrace_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned NREG         = 32,
   parameter bit          HALT_ON_ZERO = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      delta_mode,
   input  logic                      commit_valid,
   output logic                      commit_ready,
   input  logic [XLEN-1:0]           commit_pc,
   input  logic [XLEN-1:0]           commit_inst,
   input  logic [NREG*XLEN-1:0]      commit_regs,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [1:0]                out_kind,
   output logic [$clog2(NREG)-1:0]   out_idx,
   output logic [XLEN-1:0]           out_data,
   output logic                      out_last,
   output logic                      halted,
   output logic [31:0]               frame_cnt
);

   localparam int unsigned IW = $clog2(NREG);

   state_t               state_q, state_d;
   logic [XLEN-1:0]      pc_q, inst_q;
   logic [NREG*XLEN-1:0] regs_q, shadow_q;
   logic                 full_q, shadow_valid_q, halted_q;
   logic [IW-1:0]        idx_q, idx_d, last_q, last_d;
   logic [NREG-1:0]      mask_q, mask_d;
   logic                 any_q, any_d;
   logic [31:0]          frame_cnt_q;

   logic                 accept, halt_set, frame_done, wr_shadow, hs;

   logic [NREG-1:0]      cm_mask;
   logic                 cm_any;
   logic [IW-1:0]        cm_last;

   logic                 ov_q, ov_d, olast_q, olast_d;
   logic [1:0]           kind_q, kind_d;
   logic [IW-1:0]        oidx_q, oidx_d;
   logic [XLEN-1:0]      odata_q, odata_d;

   regtrace_change_mask #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_change_mask (
      .regs      (regs_q),
      .shadow    (shadow_q),
      .force_all (full_q || !shadow_valid_q),
      .mask      (cm_mask),
      .any       (cm_any),
      .last_idx  (cm_last)
   );

   assign hs = ov_q && out_ready;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mask_d     = mask_q;
      last_d     = last_q;
      any_d      = any_q;
      accept     = 1'b0;
      halt_set   = 1'b0;
      frame_done = 1'b0;
      wr_shadow  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (commit_valid) begin
               if (HALT_ON_ZERO && commit_inst == '0) begin
                  state_d  = ST_HALT;
                  halt_set = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = ST_PC;
               end
            end
         end
         ST_PC: begin
            // Snapshot is latched by now; freeze the emit plan for this frame.
            if (hs) begin
               state_d = ST_INST;
               mask_d  = cm_mask;
               last_d  = cm_last;
               any_d   = cm_any;
            end
         end
         ST_INST: begin
            if (hs) begin
               idx_d = '0;
               if (any_q) begin
                  state_d = ST_SCAN;
               end else begin
                  state_d    = ST_IDLE;
                  frame_done = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            if (!mask_q[idx_q] || hs) begin
               wr_shadow = mask_q[idx_q];
               if (idx_q == IW'(NREG - 1)) begin
                  state_d    = ST_IDLE;
                  frame_done = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so the port values come straight from flops.
      ov_d    = 1'b0;
      kind_d  = KIND_PC;
      oidx_d  = '0;
      odata_d = '0;
      olast_d = 1'b0;
      case (state_d)
         ST_PC: begin
            ov_d    = 1'b1;
            odata_d = accept ? commit_pc : pc_q;
         end
         ST_INST: begin
            ov_d    = 1'b1;
            kind_d  = KIND_INST;
            odata_d = inst_q;
            olast_d = !any_d;
         end
         ST_SCAN: begin
            ov_d    = mask_d[idx_d];
            kind_d  = KIND_REG;
            oidx_d  = idx_d;
            odata_d = regs_q[idx_d*XLEN +: XLEN];
            olast_d = mask_d[idx_d] && (idx_d == last_d);
         end
         default: begin
            ov_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         mask_q         <= '0;
         last_q         <= '0;
         any_q          <= 1'b0;
         shadow_valid_q <= 1'b0;
         halted_q       <= 1'b0;
         frame_cnt_q    <= '0;
         ov_q           <= 1'b0;
         kind_q         <= KIND_PC;
         oidx_q         <= '0;
         odata_q        <= '0;
         olast_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         last_q  <= last_d;
         any_q   <= any_d;
         if (halt_set) begin
            halted_q <= 1'b1;
         end
         if (frame_done) begin
            shadow_valid_q <= 1'b1;
            frame_cnt_q    <= frame_cnt_q + 32'd1;
         end
         ov_q    <= ov_d;
         kind_q  <= kind_d;
         oidx_q  <= oidx_d;
         odata_q <= odata_d;
         olast_q <= olast_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         pc_q   <= commit_pc;
         inst_q <= commit_inst;
         regs_q <= commit_regs;
         full_q <= !delta_mode;
      end
      if (!rst && wr_shadow) begin
         shadow_q[idx_q*XLEN +: XLEN] <= regs_q[idx_q*XLEN +: XLEN];
      end
   end

   assign commit_ready = (state_q == ST_IDLE);
   assign out_valid    = ov_q;
   assign out_kind     = kind_q;
   assign out_idx      = oidx_q;
   assign out_data     = odata_q;
   assign out_last     = olast_q;
   assign halted       = halted_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_regtrace_streamer.sv
// Directed bench for regtrace_streamer: a queue-based frame model checked
// every cycle, plus literal expectations for the planned scenarios.
module tb_regtrace_streamer;
   import regtrace_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned IW   = $clog2(NREG);

   typedef struct packed {
      logic [1:0]      kind;
      logic [IW-1:0]   idx;
      logic [XLEN-1:0] data;
      logic            last;
   } word_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 delta_mode = 1'b0;
   logic                 commit_valid = 1'b0;
   logic                 commit_ready;
   logic [XLEN-1:0]      commit_pc = '0;
   logic [XLEN-1:0]      commit_inst = '0;
   logic [NREG*XLEN-1:0] commit_regs = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [1:0]           out_kind;
   logic [IW-1:0]        out_idx;
   logic [XLEN-1:0]      out_data;
   logic                 out_last;
   logic                 halted;
   logic [31:0]          frame_cnt;

   int total = 0;
   int bad   = 0;

   word_t           expq[$];
   word_t           logq[$];
   int              emit[$];
   logic [XLEN-1:0] m_sh[NREG];
   bit              m_sv = 1'b0;
   bit              m_halted = 1'b0;
   int              m_frames = 0;
   bit              pc_chk = 1'b0;
   bit              prev_stall = 1'b0;
   int              negcnt = 0;
   int              last_neg = 0;
   int              acc_gap = 0;

   regtrace_streamer #(
      .XLEN         (XLEN),
      .NREG         (NREG),
      .HALT_ON_ZERO (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .delta_mode   (delta_mode),
      .commit_valid (commit_valid),
      .commit_ready (commit_ready),
      .commit_pc    (commit_pc),
      .commit_inst  (commit_inst),
      .commit_regs  (commit_regs),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_kind     (out_kind),
      .out_idx      (out_idx),
      .out_data     (out_data),
      .out_last     (out_last),
      .halted       (halted),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Frame model: the word list a commit must produce, from the snapshot and model shadow.
   always @(negedge clk) begin
      word_t w;
      negcnt++;
      if (pc_chk) begin
         chk("pc_latency_valid", out_valid, 1);
         chk("pc_latency_kind", out_kind, KIND_PC);
         pc_chk = 1'b0;
      end
      if (prev_stall) chk("stall_keeps_valid", out_valid, 1);
      chk("halted", halted, m_halted);
      if (m_halted || expq.size() != 0) chk("commit_ready_busy", commit_ready, 0);
      if (expq.size() == 0) begin
         chk("no_word_expected", out_valid, 0);
      end else if (out_valid) begin
         w = expq[0];
         chk("word_kind", out_kind, w.kind);
         chk("word_idx", out_idx, w.idx);
         chk("word_data", out_data, w.data);
         chk("word_last", out_last, w.last);
      end

      if (rst) begin
         expq.delete();
         m_sv = 1'b0;
         m_halted = 1'b0;
         m_frames = 0;
         pc_chk = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (out_valid && out_ready && expq.size() != 0) begin
            w = expq.pop_front();
            logq.push_back({out_kind, out_idx, out_data, out_last});
            if (w.last) begin
               m_frames++;
               last_neg = negcnt;
            end
         end
         prev_stall = out_valid && !out_ready;
         if (commit_valid && commit_ready) begin
            acc_gap = negcnt - last_neg;
            if (commit_inst == '0) begin
               m_halted = 1'b1;
            end else begin
               emit.delete();
               for (int i = 0; i < NREG; i++)
                  if (!delta_mode || !m_sv || commit_regs[i*XLEN +: XLEN] != m_sh[i])
                     emit.push_back(i);
               w.kind = KIND_PC;   w.idx = '0; w.data = commit_pc;   w.last = 1'b0;
               expq.push_back(w);
               w.kind = KIND_INST; w.idx = '0; w.data = commit_inst; w.last = (emit.size() == 0);
               expq.push_back(w);
               for (int k = 0; k < emit.size(); k++) begin
                  w.kind = KIND_REG;
                  w.idx  = IW'(emit[k]);
                  w.data = commit_regs[emit[k]*XLEN +: XLEN];
                  w.last = (k == emit.size() - 1);
                  expq.push_back(w);
                  m_sh[emit[k]] = w.data;
               end
               m_sv = 1'b1;
               pc_chk = 1'b1;
            end
         end
      end
   end

   function automatic logic [NREG*XLEN-1:0] ramp();
      logic [NREG*XLEN-1:0] r;
      for (int i = 0; i < NREG; i++) r[i*XLEN +: XLEN] = XLEN'(i);
      return r;
   endfunction

   // All stimulus tasks start and end at posedge+1.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic do_commit(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                            input logic [NREG*XLEN-1:0] r, input logic dm);
      int n;
      commit_valid = 1'b1;
      commit_pc    = pc;
      commit_inst  = inst;
      commit_regs  = r;
      delta_mode   = dm;
      n = 0;
      @(negedge clk);
      while (!commit_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("commit_accepted", commit_ready, 1);
      @(posedge clk); #1;
      commit_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit bp);
      int n;
      n = 0;
      @(negedge clk);
      while (!(expq.size() == 0 && commit_ready) && n < 3000) begin
         @(posedge clk); #1;
         if (bp) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      chk("idle_reached", commit_ready, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
   endtask

   initial begin
      logic [NREG*XLEN-1:0] r;
      int n;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_commit_ready", commit_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_kind", out_kind, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_halted", halted, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      @(posedge clk); #1;

      // Full frame, sink always ready.
      logq.delete();
      do_commit(32'h0040_0000, 32'h2008_0005, ramp(), 1'b0);
      wait_idle(1'b0);
      chk("f1_words", logq.size(), 34);
      chk("f1_pc", {logq[0].kind, logq[0].data}, {KIND_PC, 32'h0040_0000});
      chk("f1_inst", {logq[1].kind, logq[1].data, logq[1].last}, {KIND_INST, 32'h2008_0005, 1'b0});
      chk("f1_reg0", {logq[2].kind, logq[2].idx, logq[2].data}, {KIND_REG, 5'd0, 32'd0});
      chk("f1_reg31", {logq[33].kind, logq[33].idx, logq[33].data, logq[33].last},
          {KIND_REG, 5'd31, 32'd31, 1'b1});
      chk("f1_frame_cnt", frame_cnt, 1);

      // Same frame under random backpressure.
      logq.delete();
      do_commit(32'h0040_0000, 32'h2008_0005, ramp(), 1'b0);
      wait_idle(1'b1);
      chk("bp_words", logq.size(), 34);
      chk("bp_reg17", {logq[19].idx, logq[19].data}, {5'd17, 32'd17});
      chk("bp_reg31_last", {logq[33].data, logq[33].last}, {32'd31, 1'b1});
      chk("bp_frame_cnt", frame_cnt, 2);

      // Delta mode after reset: all, then only reg 8, then nothing.
      do_reset();
      logq.delete();
      do_commit(32'h0040_0010, 32'h0000_0013, ramp(), 1'b1);
      wait_idle(1'b0);
      chk("d1_words", logq.size(), 34);
      r = ramp();
      r[8*XLEN +: XLEN] = 32'h5;
      logq.delete();
      do_commit(32'h0040_0014, 32'h0000_0513, r, 1'b1);
      wait_idle(1'b0);
      chk("d2_words", logq.size(), 3);
      chk("d2_inst_not_last", logq[1].last, 0);
      chk("d2_reg8", {logq[2].kind, logq[2].idx, logq[2].data, logq[2].last},
          {KIND_REG, 5'd8, 32'h5, 1'b1});
      logq.delete();
      do_commit(32'h0040_0018, 32'h0000_0013, r, 1'b1);
      wait_idle(1'b0);
      chk("d3_words", logq.size(), 2);
      chk("d3_inst_last", {logq[1].kind, logq[1].last}, {KIND_INST, 1'b1});
      chk("d3_frame_cnt", frame_cnt, 3);
      chk("d3_model_frames", frame_cnt, m_frames);

      // Second commit held while the first frame streams.
      do_commit(32'h0000_1000, 32'h0000_0013, ramp(), 1'b0);
      r = ramp();
      r[3*XLEN +: XLEN] = 32'hdead;
      do_commit(32'h0000_1004, 32'h0000_0093, r, 1'b0);
      chk("held_accept_gap", acc_gap, 1);
      wait_idle(1'b0);
      chk("held_frame_cnt", frame_cnt, 5);

      // Reset while REG 10 is on the bus.
      do_reset();
      do_commit(32'h0000_2000, 32'h0000_0013, ramp(), 1'b1);
      n = 0;
      while (!(out_valid && out_kind == KIND_REG && out_idx == 5'd10) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reached_idx10", out_idx, 10);
      do_reset();
      @(negedge clk);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_last", out_last, 0);
      chk("abort_frame_cnt", frame_cnt, 0);
      @(posedge clk); #1;
      logq.delete();
      do_commit(32'h0000_2004, 32'h0000_0013, ramp(), 1'b1);
      wait_idle(1'b0);
      chk("post_abort_words", logq.size(), 34);
      chk("post_abort_frame_cnt", frame_cnt, 1);

      // Zero instruction halts; later commits are ignored until reset.
      do_commit(32'h0000_3000, 32'h0000_0000, ramp(), 1'b0);
      commit_valid = 1'b1;
      commit_inst  = 32'h0000_0013;
      repeat (6) begin
         @(posedge clk); #1;
      end
      commit_valid = 1'b0;
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_commit_ready", commit_ready, 0);
      chk("halt_out_valid", out_valid, 0);
      chk("halt_frame_cnt", frame_cnt, 1);
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      chk("unhalt_halted", halted, 0);
      chk("unhalt_commit_ready", commit_ready, 1);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
